// File: rtl/spidergon_pkg.sv
// Shared encodings and width helpers for the Spidergon traffic injector.
package spidergon_pkg;

   typedef logic [1:0] flit_type_t;

   localparam flit_type_t FLIT_BODY      = 2'b00;
   localparam flit_type_t FLIT_HEAD      = 2'b01;
   localparam flit_type_t FLIT_TAIL      = 2'b10;
   localparam flit_type_t FLIT_HEAD_TAIL = 2'b11;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ALLOC = 2'd1;
   localparam logic [1:0] ST_SEND  = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   function automatic int NODE_ID_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int VC_ID_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Encoding is {is_tail, is_head}, so a single-flit packet naturally becomes HEAD_TAIL.
   function automatic flit_type_t flit_type_of(input logic first, input logic last);
      return {last, first};
   endfunction

endpackage

// File: rtl/spidergon_credit_counter.sv
// Per-VC saturating credit counter with an overflow pulse for returns at max.
module spidergon_credit_counter #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic dec,
   input  logic inc,
   output logic has_credit,
   output logic ovf
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0] cnt;

   assign has_credit = (cnt != '0);
   assign ovf        = inc && !dec && (cnt == CW'(DEPTH));

   // A simultaneous send and return leave the count untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= CW'(DEPTH);
      end else if (inc && !dec) begin
         if (cnt != CW'(DEPTH)) cnt <= cnt + 1'b1;
      end else if (dec && !inc) begin
         if (cnt != '0) cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/spidergon_traffic_injector.sv
// Synthetic wormhole packet source for one Spidergon node's local injection port.
module spidergon_traffic_injector
   import spidergon_pkg::*;
#(
   parameter int          NUM_OF_NODES            = 8,
   parameter int          FLIT_DATA_WIDTH         = 16,
   parameter int          NUM_OF_VIRTUAL_CHANNELS = 2,
   parameter int          VC_BUFFER_DEPTH         = 2,
   parameter int          FLITS_PER_PACKET        = 4,
   parameter int          NODE_ID                 = 0,
   parameter logic [15:0] LFSR_SEED               = 16'hACE1
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          enable,
   input  logic [7:0]                                    inject_gap,
   input  logic [NUM_OF_VIRTUAL_CHANNELS-1:0]            credit_return,
   output logic                                          flit_valid,
   output logic [1:0]                                    flit_type,
   output logic [VC_ID_W(NUM_OF_VIRTUAL_CHANNELS)-1:0]   flit_vc,
   output logic [NODE_ID_W(NUM_OF_NODES)-1:0]            flit_dest,
   output logic [FLIT_DATA_WIDTH-1:0]                    flit_data,
   output logic [15:0]                                   packets_sent,
   output logic                                          credit_error,
   output logic                                          busy
);
   localparam int NVC = NUM_OF_VIRTUAL_CHANNELS;
   localparam int NW  = NODE_ID_W(NUM_OF_NODES);
   localparam int VW  = VC_ID_W(NVC);
   localparam int IW  = (FLITS_PER_PACKET > 1) ? $clog2(FLITS_PER_PACKET) : 1;

   logic [1:0]      state, state_nx, after_tail;
   logic [15:0]     lfsr;
   logic [7:0]      gap_cnt;
   logic [VW-1:0]   rr_ptr, cur_vc, pick_vc, cand, fire_vc;
   logic [NW-1:0]   cur_dest, lfsr_dest, fire_dest;
   logic [IW-1:0]   flit_idx, fire_idx;
   logic            found, alloc_fire, send_fire, fire, fire_last;
   logic [NVC-1:0]  has_credit, dec, ovf;
   logic [8+IW-1:0] data_raw;

   spidergon_credit_counter #(.DEPTH(VC_BUFFER_DEPTH)) u_cc [NVC-1:0] (
      .clk        (clk),
      .reset      (reset),
      .dec        (dec),
      .inc        (credit_return),
      .has_credit (has_credit),
      .ovf        (ovf)
   );

   // Round-robin: first VC with credit, scanning upward from rr_ptr.
   always_comb begin
      found   = 1'b0;
      pick_vc = '0;
      cand    = '0;
      for (int i = 0; i < NVC; i++) begin
         cand = VW'((int'(rr_ptr) + i) % NVC);
         if (!found && has_credit[cand]) begin
            found   = 1'b1;
            pick_vc = cand;
         end
      end
   end

   assign lfsr_dest = (lfsr[NW-1:0] == NW'(NODE_ID)) ? NW'(NODE_ID + 1) : lfsr[NW-1:0];

   // The head leaves on the ALLOC exit edge; SEND carries the remaining flits.
   assign alloc_fire = (state == ST_ALLOC) && found;
   assign send_fire  = (state == ST_SEND) && has_credit[cur_vc];
   assign fire       = alloc_fire || send_fire;
   assign fire_vc    = alloc_fire ? pick_vc   : cur_vc;
   assign fire_dest  = alloc_fire ? lfsr_dest : cur_dest;
   assign fire_idx   = alloc_fire ? '0        : flit_idx;
   assign fire_last  = (fire_idx == IW'(FLITS_PER_PACKET - 1));
   assign data_raw   = {packets_sent[7:0], fire_idx};

   always_comb begin
      dec = '0;
      for (int v = 0; v < NVC; v++) dec[v] = fire && (fire_vc == VW'(v));
   end

   assign after_tail = (inject_gap != 8'd0) ? ST_GAP : (enable ? ST_ALLOC : ST_IDLE);

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (enable) state_nx = ST_ALLOC;
         ST_ALLOC: if (found) state_nx = fire_last ? after_tail : ST_SEND;
         ST_SEND:  if (send_fire && fire_last) state_nx = after_tail;
         ST_GAP:   if (gap_cnt == 8'd0) state_nx = enable ? ST_ALLOC : ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         lfsr         <= LFSR_SEED;
         gap_cnt      <= '0;
         rr_ptr       <= '0;
         cur_vc       <= '0;
         cur_dest     <= '0;
         flit_idx     <= '0;
         flit_valid   <= 1'b0;
         flit_type    <= FLIT_BODY;
         flit_vc      <= '0;
         flit_dest    <= '0;
         flit_data    <= '0;
         packets_sent <= '0;
         credit_error <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nx;
         busy         <= (state_nx == ST_SEND);
         credit_error <= credit_error | (|ovf);
         flit_valid   <= fire;
         flit_type    <= fire ? flit_type_of(fire_idx == '0, fire_last) : FLIT_BODY;
         flit_vc      <= fire ? fire_vc : '0;
         flit_dest    <= fire ? fire_dest : '0;
         flit_data    <= fire ? FLIT_DATA_WIDTH'(data_raw) : '0;
         if (alloc_fire) begin
            cur_vc   <= pick_vc;
            cur_dest <= lfsr_dest;
            lfsr     <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
         end
         if (fire) flit_idx <= fire_last ? '0 : fire_idx + 1'b1;
         if (fire && fire_last) begin
            packets_sent <= packets_sent + 1'b1;
            rr_ptr       <= VW'((int'(fire_vc) + 1) % NVC);
         end
         if (state_nx == ST_GAP && state != ST_GAP) gap_cnt <= inject_gap - 8'd1;
         else if (state == ST_GAP && gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
      end
   end

endmodule

// File: tb/tb_spidergon_traffic_injector.sv
// Directed bench: three injector instances covering 4-flit, 2-flit and 1-flit packet shapes.
module tb_spidergon_traffic_injector;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   // Instance A: defaults, NODE_ID 0, seed ACE1
   logic        rst_a, en_a, auto_a;
   logic [7:0]  gap_a;
   logic [1:0]  cra_auto, cra_man, cr_a;
   logic        a_valid, a_vc, a_cerr, a_busy;
   logic [1:0]  a_type;
   logic [2:0]  a_dest;
   logic [15:0] a_data, a_sent;

   // Instance B: 2-flit packets, NODE_ID 3, seed low bits 3
   logic        rst_b, en_b, auto_b;
   logic [7:0]  gap_b;
   logic [1:0]  crb_auto, crb_man, cr_b;
   logic        b_valid, b_vc, b_cerr, b_busy;
   logic [1:0]  b_type;
   logic [2:0]  b_dest;
   logic [15:0] b_data, b_sent;

   // Instance C: single-flit packets
   logic        rst_c, en_c, auto_c;
   logic [7:0]  gap_c;
   logic [1:0]  crc_auto, crc_man, cr_c;
   logic        c_valid, c_vc, c_cerr, c_busy;
   logic [1:0]  c_type;
   logic [2:0]  c_dest;
   logic [15:0] c_data, c_sent;

   assign cr_a = cra_auto | cra_man;
   assign cr_b = crb_auto | crb_man;
   assign cr_c = crc_auto | crc_man;

   spidergon_traffic_injector u_a (
      .clk(clk), .reset(rst_a), .enable(en_a), .inject_gap(gap_a), .credit_return(cr_a),
      .flit_valid(a_valid), .flit_type(a_type), .flit_vc(a_vc), .flit_dest(a_dest),
      .flit_data(a_data), .packets_sent(a_sent), .credit_error(a_cerr), .busy(a_busy));

   spidergon_traffic_injector #(.FLITS_PER_PACKET(2), .NODE_ID(3), .LFSR_SEED(16'hACE3)) u_b (
      .clk(clk), .reset(rst_b), .enable(en_b), .inject_gap(gap_b), .credit_return(cr_b),
      .flit_valid(b_valid), .flit_type(b_type), .flit_vc(b_vc), .flit_dest(b_dest),
      .flit_data(b_data), .packets_sent(b_sent), .credit_error(b_cerr), .busy(b_busy));

   spidergon_traffic_injector #(.FLITS_PER_PACKET(1)) u_c (
      .clk(clk), .reset(rst_c), .enable(en_c), .inject_gap(gap_c), .credit_return(cr_c),
      .flit_valid(c_valid), .flit_type(c_type), .flit_vc(c_vc), .flit_dest(c_dest),
      .flit_data(c_data), .packets_sent(c_sent), .credit_error(c_cerr), .busy(c_busy));

   // Router model: frees the slot of every flit seen, one cycle later.
   always @(negedge clk) begin
      cra_auto = '0;
      crb_auto = '0;
      crc_auto = '0;
      if (auto_a && a_valid) cra_auto[a_vc] = 1'b1;
      if (auto_b && b_valid) crb_auto[b_vc] = 1'b1;
      if (auto_c && c_valid) crc_auto[c_vc] = 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {valid, type, vc, dest, data} of instance A against an expected flit
   task automatic chk_a(input string tag, input logic [1:0] t, input logic v,
                        input logic [2:0] d, input logic [15:0] data);
      chk(tag, {a_valid, a_type, a_vc, a_dest, a_data}, {1'b1, t, v, d, data});
   endtask

   task automatic wait_flit_a(output int idle);
      idle = 0;
      @(negedge clk);
      while (!a_valid && idle < 50) begin
         idle++;
         @(negedge clk);
      end
   endtask

   initial begin
      int idle, n0, n1, nf, bad, tails, cyc;
      logic [2:0] first_dest;
      logic [1:0] seen_type;
      logic       seen_vc;

      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
      gap_a = 8'd0; gap_b = 8'd0; gap_c = 8'd0;
      auto_a = 1'b0; auto_b = 1'b0; auto_c = 1'b0;
      cra_man = '0; crb_man = '0; crc_man = '0;
      cra_auto = '0; crb_auto = '0; crc_auto = '0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {a_valid, a_type, a_vc, a_dest, a_data, a_sent, a_cerr, a_busy}, '0);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

      // Packets 0 and 1: gap 0, credits returned per flit. Dests from LFSR ACE1 -> 1, 1.
      auto_a = 1'b1;
      en_a   = 1'b1;
      @(negedge clk);
      chk("first_cycle_idle", a_valid, 1'b0);
      @(negedge clk);
      chk_a("pkt0_head", 2'b01, 1'b0, 3'd1, 16'd0);
      chk("pkt0_busy", a_busy, 1'b1);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         chk_a($sformatf("pkt0_flit%0d", k), (k == 3) ? 2'b10 : 2'b00, 1'b0, 3'd1, 16'(k));
      end
      chk("pkt0_sent", a_sent, 16'd1);
      chk("pkt0_busy_tail", a_busy, 1'b0);
      @(negedge clk);
      chk_a("pkt1_head", 2'b01, 1'b1, 3'd1, 16'd4);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         chk_a($sformatf("pkt1_flit%0d", k), (k == 3) ? 2'b10 : 2'b00, 1'b1, 3'd1, 16'(4 + k));
      end
      chk("pkt1_sent", a_sent, 16'd2);

      // Packet 2 is already allocated; the gap applies after its tail.
      gap_a = 8'd5;
      @(negedge clk);
      chk_a("pkt2_head", 2'b01, 1'b0, 3'd1, 16'd8);
      repeat (3) @(negedge clk);
      chk_a("pkt2_tail", 2'b10, 1'b0, 3'd1, 16'd11);
      wait_flit_a(idle);
      chk("gap5_idle_cycles", idle, 5);
      chk_a("pkt3_head", 2'b01, 1'b1, 3'd4, 16'd12);

      // Enable drops during the packet: it still completes, then the source stays quiet.
      en_a = 1'b0;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         chk_a($sformatf("pkt3_flit%0d", k), (k == 3) ? 2'b10 : 2'b00, 1'b1, 3'd4, 16'(12 + k));
         chk($sformatf("pkt3_busy%0d", k), a_busy, (k == 3) ? 1'b0 : 1'b1);
      end
      chk("pkt3_sent", a_sent, 16'd4);
      nf = 0;
      repeat (12) begin
         @(negedge clk);
         if (a_valid || a_busy) nf++;
      end
      chk("disabled_quiet", nf, 0);
      chk("a_no_credit_error", a_cerr, 1'b0);

      // Reset in the middle of packet 4 (vc0, LFSR value 2ACE -> dest 6).
      gap_a = 8'd0;
      en_a  = 1'b1;
      wait_flit_a(idle);
      chk("restart_latency", idle, 1);
      chk_a("pkt4_head", 2'b01, 1'b0, 3'd6, 16'd16);
      @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      chk("midpkt_reset_outputs", {a_valid, a_type, a_vc, a_dest, a_data, a_sent, a_cerr, a_busy}, '0);
      rst_a = 1'b0;
      en_a  = 1'b0;

      // Instance B without returns: two packets of two flits, one per VC, then starvation.
      n0 = 0; n1 = 0; first_dest = 3'd0;
      en_b = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (b_valid) begin
            if (n0 + n1 == 0) first_dest = b_dest;
            if (b_vc) n1++; else n0++;
         end
      end
      chk("nocredit_vc0_flits", n0, 2);
      chk("nocredit_vc1_flits", n1, 2);
      chk("node3_first_dest", first_dest, 3'd4);
      crb_man = 2'b01;
      @(negedge clk);
      crb_man = 2'b00;
      nf = 0; seen_type = 2'b00; seen_vc = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (b_valid) begin
            nf++;
            seen_type = b_type;
            seen_vc   = b_vc;
         end
      end
      chk("one_credit_one_flit", nf, 1);
      chk("one_credit_flit", {seen_type, seen_vc}, {2'b01, 1'b0});

      // Give back the held credits, then run 1000 packets with returns, never to self.
      auto_b  = 1'b1;
      crb_man = 2'b11;
      @(negedge clk);
      @(negedge clk);
      crb_man = 2'b00;
      bad = 0; tails = 0; cyc = 0;
      while (tails < 1000 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (b_valid) begin
            if (b_dest == 3'd3) bad++;
            if (b_type == 2'b10) tails++;
         end
      end
      chk("node3_tails_seen", tails, 1000);
      chk("node3_self_dest", bad, 0);
      chk("node3_packets_sent", b_sent, 16'd1003);
      chk("b_no_credit_error", b_cerr, 1'b0);
      en_b = 1'b0;

      // Instance C: single-flit packets alternate VCs at one per cycle.
      auto_c = 1'b1;
      en_c   = 1'b1;
      nf = 0; bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (c_valid) begin
            nf++;
            if (c_type != 2'b11) bad++;
         end
      end
      chk("single_flit_count", nf, 19);
      chk("single_flit_types", bad, 0);
      en_c = 1'b0;
      repeat (5) @(negedge clk);
      chk("c_error_before", c_cerr, 1'b0);
      crc_man = 2'b10;
      @(negedge clk);
      crc_man = 2'b00;
      chk("overflow_sets_error", c_cerr, 1'b1);
      repeat (5) @(negedge clk);
      chk("error_sticky", c_cerr, 1'b1);
      rst_c = 1'b1;
      @(negedge clk);
      rst_c = 1'b0;
      chk("error_cleared_by_reset", c_cerr, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
